// File: rtl/ether_tx_arbiter.sv
// Round-robin arbiter that serializes whole frames from two byte-stream requesters
// onto the RMII transmit dibit pins. It adds preamble and SFD, then enforces the inter-frame gap.
module ether_tx_arbiter #(
    parameter int PREAMBLE_BYTES = 7,
    parameter int IFG_BYTES      = 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req0_tdata,
    input  logic       req0_tvalid,
    input  logic       req0_tlast,
    output logic       req0_tready,
    input  logic [7:0] req1_tdata,
    input  logic       req1_tvalid,
    input  logic       req1_tlast,
    output logic       req1_tready,
    output logic [1:0] txd,
    output logic       txen,
    output logic [1:0] grant,
    output logic       underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_IFG
    } state_t;

    localparam logic [5:0] PRE_LAST = 6'(PREAMBLE_BYTES - 1);
    localparam logic [5:0] IFG_LAST = 6'(IFG_BYTES - 1);

    state_t     state, state_n;
    logic [1:0] dibit_cnt, dibit_n;
    logic [5:0] byte_cnt, byte_n;
    logic [1:0] grant_n;
    logic       last_grant, last_grant_n;
    logic       hs, hs_n;
    logic       underrun_n;
    logic [7:0] data_byte, data_n;
    logic       data_last, last_n;

    logic       own_valid, own_last;
    logic [7:0] own_data;
    logic [7:0] cur_byte;

    assign own_valid = grant[1] ? req1_tvalid : req0_tvalid;
    assign own_last  = grant[1] ? req1_tlast  : req0_tlast;
    assign own_data  = grant[1] ? req1_tdata  : req0_tdata;

    // The handshake is decided one cycle ahead (dibit 2) so tready and underrun come
    // straight from flops. The requester holds tvalid steady across a frame.
    assign req0_tready = hs & grant[0];
    assign req1_tready = hs & grant[1];
    assign txen        = (state == S_PREAMBLE) || (state == S_SFD) || (state == S_DATA);

    always_comb begin
        cur_byte = 8'h00;
        unique case (state)
            S_PREAMBLE: cur_byte = 8'h55;
            S_SFD:      cur_byte = 8'hD5;
            S_DATA:     cur_byte = data_byte;
            default:    cur_byte = 8'h00;
        endcase
        txd = cur_byte[{dibit_cnt, 1'b0} +: 2];
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_n      = state;
        dibit_n      = dibit_cnt + 2'd1;
        byte_n       = byte_cnt;
        grant_n      = grant;
        last_grant_n = last_grant;
        hs_n         = 1'b0;
        underrun_n   = 1'b0;
        data_n       = data_byte;
        last_n       = data_last;

        if (((state == S_SFD) || ((state == S_DATA) && !data_last)) && (dibit_cnt == 2'd2)) begin
            hs_n       = own_valid;
            underrun_n = !own_valid;
        end
        if (hs) begin
            data_n = own_data;
            last_n = own_last;
        end

        unique case (state)
            S_IDLE: begin
                dibit_n = 2'd0;
                byte_n  = 6'd0;
                if (req0_tvalid || req1_tvalid) begin
                    last_grant_n = req1_tvalid && (!req0_tvalid || !last_grant);
                    grant_n      = last_grant_n ? 2'b10 : 2'b01;
                    state_n      = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                if (dibit_cnt == 2'd3) begin
                    if (byte_cnt == PRE_LAST) begin
                        state_n = S_SFD;
                        byte_n  = 6'd0;
                    end else begin
                        byte_n = byte_cnt + 6'd1;
                    end
                end
            end
            S_SFD: begin
                if (dibit_cnt == 2'd3) begin
                    state_n = hs ? S_DATA : S_IFG;
                    grant_n = hs ? grant : 2'b00;
                end
            end
            S_DATA: begin
                if ((dibit_cnt == 2'd3) && (data_last || !hs)) begin
                    state_n = S_IFG;
                    grant_n = 2'b00;
                    byte_n  = 6'd0;
                end
            end
            S_IFG: begin
                // The gap counts the IDLE arbitration cycle, so IFG itself ends one clk early.
                if ((byte_cnt == IFG_LAST) && (dibit_cnt == 2'd2)) begin
                    state_n = S_IDLE;
                end else if (dibit_cnt == 2'd3) begin
                    byte_n = byte_cnt + 6'd1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop updates from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            dibit_cnt  <= 2'd0;
            byte_cnt   <= 6'd0;
            grant      <= 2'b00;
            last_grant <= 1'b1;
            hs         <= 1'b0;
            underrun   <= 1'b0;
            data_byte  <= 8'h00;
            data_last  <= 1'b0;
        end else begin
            state      <= state_n;
            dibit_cnt  <= dibit_n;
            byte_cnt   <= byte_n;
            grant      <= grant_n;
            last_grant <= last_grant_n;
            hs         <= hs_n;
            underrun   <= underrun_n;
            data_byte  <= data_n;
            data_last  <= last_n;
        end
    end

endmodule

// File: tb/tb_ether_tx_arbiter.sv
// Directed bench for ether_tx_arbiter: table-driven single-requester frames plus
// hand sequences for tie-break, non-owner blocking, underrun and mid-frame reset.
module tb_ether_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tdata  [2];
    logic       tvalid [2];
    logic       tlast  [2];
    logic       req0_tready, req1_tready;
    logic [1:0] txd;
    logic       txen;
    logic [1:0] grant;
    logic       underrun;

    always #10 clk = ~clk;

    ether_tx_arbiter #(.PREAMBLE_BYTES(7), .IFG_BYTES(12)) dut (
        .clk(clk), .rst(rst),
        .req0_tdata(tdata[0]), .req0_tvalid(tvalid[0]), .req0_tlast(tlast[0]), .req0_tready(req0_tready),
        .req1_tdata(tdata[1]), .req1_tvalid(tvalid[1]), .req1_tlast(tlast[1]), .req1_tready(req1_tready),
        .txd(txd), .txen(txen), .grant(grant), .underrun(underrun)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Frame sources: a byte stays presented until the cycle after its tready pulse.
    logic [7:0] fbuf [2][8];
    int         flen [2];
    int         fpos [2];
    int         fdrop[2];
    bit         fon  [2];
    bit         pend [2];

    function automatic logic rdy(input int i);
        return (i == 0) ? req0_tready : req1_tready;
    endfunction

    function automatic void drive(input int i);
        if (fon[i] && fpos[i] < flen[i] && fpos[i] < fdrop[i]) begin
            tvalid[i] = 1'b1;
            tdata[i]  = fbuf[i][fpos[i]];
            tlast[i]  = (fpos[i] == flen[i] - 1);
        end else begin
            tvalid[i] = 1'b0;
            tdata[i]  = 8'h00;
            tlast[i]  = 1'b0;
        end
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (pend[i]) begin
                fpos[i]++;
                pend[i] = 1'b0;
            end
            if (fon[i] && rdy(i)) pend[i] = 1'b1;
            drive(i);
        end
    end

    task automatic load(input int i, input int len, input logic [31:0] bytes, input int drop);
        for (int k = 0; k < 4; k++) fbuf[i][k] = bytes[8*k +: 8];
        flen[i]  = len;
        fpos[i]  = 0;
        fdrop[i] = drop;
        pend[i]  = 1'b0;
        fon[i]   = 1'b1;
        drive(i);
    endtask

    task automatic stop_src(input int i);
        fon[i]  = 1'b0;
        pend[i] = 1'b0;
        drive(i);
    endtask

    // Results of the most recent run_frame call.
    logic [1:0] cap [256];
    int wait_n, hi_n, rdy_own, rdy_oth, und_n, und_at, first_rdy, last_rdy, bad_grant, gap_bad;

    task automatic run_frame(input int own, input logic [1:0] exp_grant);
        wait_n = 0; hi_n = 0; rdy_own = 0; rdy_oth = 0; und_n = 0; und_at = -1;
        first_rdy = -1; last_rdy = -1; bad_grant = 0; gap_bad = 0;
        while (!txen && wait_n < 200) begin
            if (grant !== 2'b00 || req0_tready || req1_tready) gap_bad++;
            @(negedge clk);
            wait_n++;
        end
        if (!txen) begin
            check("txen_rise_timeout", wait_n, 0);
            return;
        end
        while (txen && hi_n < 250) begin
            cap[hi_n] = txd;
            if (grant !== exp_grant) bad_grant++;
            if (rdy(own)) begin
                rdy_own++;
                if (first_rdy < 0) first_rdy = hi_n;
                last_rdy = hi_n;
            end
            if (rdy(1 - own)) rdy_oth++;
            if (underrun) begin
                und_n++;
                und_at = hi_n;
            end
            @(negedge clk);
            hi_n++;
        end
    endtask

    function automatic logic [63:0] pack_dibits(input int start, input int n);
        logic [63:0] w = '0;
        for (int k = 0; k < n; k++) w[2*k +: 2] = cap[start + k];
        return w;
    endfunction

    typedef struct {
        string       name;
        int          rid;
        int          len;
        logic [31:0] bytes;     // byte k in bits [8k +: 8]
        int          exp_hi;
        logic [1:0]  exp_d[16];
    } vec_t;

    vec_t vecs[4];
    logic [63:0] hdr_exp;
    logic [63:0] dat_exp;

    initial begin
        vecs[0] = '{"r0_3byte", 0, 3, 32'h00C3B2A1, 44,
                    '{2'd1,2'd0,2'd2,2'd2, 2'd2,2'd0,2'd3,2'd2, 2'd3,2'd0,2'd0,2'd3, 2'd0,2'd0,2'd0,2'd0}};
        vecs[1] = '{"r1_1byte_ff", 1, 1, 32'h000000FF, 36,
                    '{2'd3,2'd3,2'd3,2'd3, 2'd0,2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0,2'd0}};
        vecs[2] = '{"r1_2byte", 1, 2, 32'h00005A00, 40,
                    '{2'd0,2'd0,2'd0,2'd0, 2'd2,2'd2,2'd1,2'd1, 2'd0,2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0,2'd0}};
        vecs[3] = '{"r0_1byte_36", 0, 1, 32'h00000036, 36,
                    '{2'd2,2'd1,2'd3,2'd0, 2'd0,2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0,2'd0, 2'd0,2'd0,2'd0,2'd0}};

        // 28 preamble dibits of 01, then SFD 01,01,01,11.
        hdr_exp = '0;
        for (int k = 0; k < 31; k++) hdr_exp[2*k +: 2] = 2'b01;
        hdr_exp[62 +: 2] = 2'b11;

        for (int i = 0; i < 2; i++) begin
            fon[i] = 1'b0; pend[i] = 1'b0; flen[i] = 0; fpos[i] = 0; fdrop[i] = 0;
            drive(i);
        end

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_txen", txen, 0);
        check("rst_txd", txd, 0);
        check("rst_grant", grant, 0);
        check("rst_tready", {req0_tready, req1_tready}, 0);
        check("rst_underrun", underrun, 0);
        rst = 1'b0;
        @(negedge clk);

        // Tie after reset: req0 first; req1 blocked through req0's frame and gap
        load(0, 2, 32'h00002211, 99);
        load(1, 1, 32'h000000FF, 99);
        run_frame(0, 2'b01);
        check("tie_latency", wait_n, 1);
        check("tie_grant_r0", bad_grant, 0);
        check("tie_r0_tready", rdy_own, 2);
        check("tie_r1_blocked", rdy_oth, 0);
        check("tie_r0_hi", hi_n, 40);
        run_frame(1, 2'b10);
        check("tie_gap", wait_n, 48);
        check("tie_gap_quiet", gap_bad, 0);
        check("tie_grant_r1", bad_grant, 0);
        check("tie_r1_hi", hi_n, 36);
        stop_src(0);
        stop_src(1);
        repeat (60) @(negedge clk);

        // Table-driven single-requester frames
        for (int v = 0; v < 4; v++) begin
            load(vecs[v].rid, vecs[v].len, vecs[v].bytes, 99);
            run_frame(vecs[v].rid, vecs[v].rid == 0 ? 2'b01 : 2'b10);
            dat_exp = '0;
            for (int k = 0; k < 4 * vecs[v].len; k++) dat_exp[2*k +: 2] = vecs[v].exp_d[k];
            check({vecs[v].name, "_latency"}, wait_n, 1);
            check({vecs[v].name, "_txen_len"}, hi_n, vecs[v].exp_hi);
            check({vecs[v].name, "_header"}, pack_dibits(0, 32), hdr_exp);
            check({vecs[v].name, "_data"}, pack_dibits(32, 4 * vecs[v].len), dat_exp);
            check({vecs[v].name, "_tready_cnt"}, rdy_own, vecs[v].len);
            check({vecs[v].name, "_first_tready"}, first_rdy, 31);
            check({vecs[v].name, "_tready_span"}, last_rdy - first_rdy, 4 * (vecs[v].len - 1));
            check({vecs[v].name, "_grant"}, bad_grant, 0);
            check({vecs[v].name, "_no_underrun"}, und_n, 0);
            stop_src(vecs[v].rid);
            repeat (60) @(negedge clk);
        end

        // Underrun: req1 wins the tie (req0 went last), then drops tvalid after byte 1
        load(1, 3, 32'h00302010, 1);
        load(0, 1, 32'h00000081, 99);
        run_frame(1, 2'b10);
        check("und_grant_r1", bad_grant, 0);
        check("und_txen_len", hi_n, 36);
        check("und_pulses", und_n, 1);
        check("und_position", und_at, 35);
        check("und_tready_cnt", rdy_own, 1);
        check("und_first_byte", pack_dibits(32, 4), 64'h0000_0000_0000_0010);
        check("und_r0_blocked", rdy_oth, 0);
        stop_src(1);
        run_frame(0, 2'b01);
        check("und_gap", wait_n, 48);
        check("und_gap_quiet", gap_bad, 0);
        check("und_r0_grant", bad_grant, 0);
        check("und_r0_hi", hi_n, 36);
        stop_src(0);
        repeat (60) @(negedge clk);

        // Reset mid-DATA, immediate restart with no gap, then tie goes to req0
        load(0, 4, 32'h04030201, 99);
        wait_n = 0;
        while (!txen && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        check("rstmid_started", txen, 1);
        repeat (34) @(negedge clk);
        check("rstmid_in_data", txen, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_txen", txen, 0);
        check("rstmid_grant", grant, 0);
        check("rstmid_txd", txd, 0);
        rst = 1'b0;
        stop_src(0);
        load(1, 1, 32'h000000C3, 99);
        run_frame(1, 2'b10);
        check("rstmid_no_ifg", wait_n, 1);
        check("rstmid_r1_hi", hi_n, 36);
        check("rstmid_r1_grant", bad_grant, 0);
        stop_src(1);
        repeat (60) @(negedge clk);
        load(0, 1, 32'h00000011, 99);
        load(1, 1, 32'h00000022, 99);
        run_frame(0, 2'b01);
        check("rstmid_tie_r0", bad_grant, 0);
        check("rstmid_tie_r1_blocked", rdy_oth, 0);
        stop_src(0);
        stop_src(1);
        repeat (5) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
